// File: rtl/cbus_rr_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// cbus_rr_arbiter_pkg
// Shared CBus types for the core-side arbiter and its helpers:
//   cbus_req_t  - request from a master (valid qualifies the whole struct)
//   cbus_resp_t - response beat from downstream (ready = beat accepted,
//                 last = final beat of the transaction)
//   arb_state_t - arbiter ownership state
//   arb_idx_w() - width of a channel index, never narrower than one bit
// -----------------------------------------------------------------------------
package cbus_rr_arbiter_pkg;

  localparam int CBUS_ADDR_W = 32;
  localparam int CBUS_DATA_W = 32;
  localparam int CBUS_LEN_W  = 4;

  typedef struct packed {
    logic                   valid;
    logic                   write;
    logic [CBUS_ADDR_W-1:0] addr;
    logic [CBUS_DATA_W-1:0] wdata;
    logic [CBUS_LEN_W-1:0]  len;
  } cbus_req_t;

  typedef struct packed {
    logic                   ready;
    logic                   last;
    logic [CBUS_DATA_W-1:0] rdata;
  } cbus_resp_t;

  typedef enum logic [0:0] {
    ARB_IDLE = 1'b0,
    ARB_BUSY = 1'b1
  } arb_state_t;

  // A single-channel arbiter still carries a one-bit index field.
  function automatic int arb_idx_w(input int n);
    int w;
    if (n > 1) begin
      w = $clog2(n);
    end else begin
      w = 1;
    end
    return w;
  endfunction

endpackage

// File: rtl/cbus_rr_arbiter_chk.sv
// -----------------------------------------------------------------------------
// cbus_rr_arbiter_chk
// Simulation-time protocol checker for the arbiter.
//   clk, reset  - arbiter clock and active-low reset
//   busy        - arbiter is holding the bus for an owner
//   owner_valid - valid of the channel that currently owns the bus
// An owner must keep valid high until its last response beat completes; the
// arbiter keeps the transaction going regardless, this only flags the master.
// -----------------------------------------------------------------------------
module cbus_rr_arbiter_chk (
  input logic clk,
  input logic reset,
  input logic busy,
  input logic owner_valid
);

  property p_owner_holds_valid;
    @(posedge clk) disable iff (!reset) busy |-> owner_valid;
  endproperty

  a_owner_holds_valid: assert property (p_owner_holds_valid)
    else $error("cbus_rr_arbiter: owning master dropped valid mid-transaction");

endmodule

// File: rtl/cbus_rr_arbiter_select.sv
// -----------------------------------------------------------------------------
// rr_select
// Purely combinational request selector, reusable by a response crossbar.
//   valid     - per-channel request valid
//   last_idx  - most recently granted channel (rotation origin)
//   sel       - chosen channel (0 when nothing is valid)
//   any_valid - at least one channel is requesting
// ROUND_ROBIN=1 scans last_idx+1 .. last_idx+NUM_INPUTS (mod NUM_INPUTS).
// ROUND_ROBIN=0 uses the same scan anchored at NUM_INPUTS-1, which makes the
// lowest valid index win.
// -----------------------------------------------------------------------------
module rr_select
  import cbus_rr_arbiter_pkg::*;
#(
  parameter int NUM_INPUTS  = 2,
  parameter int ROUND_ROBIN = 1,
  localparam int IDX_W      = arb_idx_w(NUM_INPUTS)
) (
  input  logic [NUM_INPUTS-1:0] valid,
  input  logic [IDX_W-1:0]      last_idx,
  output logic [IDX_W-1:0]      sel,
  output logic                  any_valid
);

  localparam int               PAD_W   = 1 << IDX_W;
  localparam logic [IDX_W-1:0] LAST_CH = IDX_W'(NUM_INPUTS - 1);

  // Padding to a power of two lets the scan index the vector with a full-width
  // index even when NUM_INPUTS is not a power of two.
  logic [PAD_W-1:0] valid_pad_s;
  logic [IDX_W-1:0] start_s;

  assign valid_pad_s = PAD_W'(valid);
  assign any_valid   = |valid;
  assign start_s     = (ROUND_ROBIN != 0) ? last_idx : LAST_CH;

  // Rotating scan: first valid channel after start_s wins.
  always_comb begin
    logic [IDX_W-1:0] scan;
    logic             hit;
    scan = start_s;
    hit  = 1'b0;
    sel  = {IDX_W{1'b0}};
    for (int k = 0; k < NUM_INPUTS; k++) begin
      if (scan == LAST_CH) begin
        scan = {IDX_W{1'b0}};
      end else begin
        scan = scan + IDX_W'(1);
      end
      if (!hit && valid_pad_s[scan]) begin
        sel = scan;
        hit = 1'b1;
      end else begin
        hit = hit;
      end
    end
  end

endmodule

// File: rtl/cbus_rr_arbiter.sv
// -----------------------------------------------------------------------------
// cbus_rr_arbiter
// N-to-1 CBus arbiter between core-side masters and the MMU/memory port.
// A grant is held for the whole transaction (bursts included) until the
// downstream beat with ready && last.
//   clk         - clock
//   reset       - asynchronous active-low reset; also forces all outputs to 0
//   ireqs       - requests from masters
//   iresps      - responses to masters (only the owner sees a non-zero beat)
//   oreq        - request to downstream
//   oresp       - response from downstream
//   grant_valid - a channel owns the bus
//   grant_index - owning channel, 0 when grant_valid=0
// BYPASS=1: an idle arbiter forwards the selected request in the same cycle,
// and a single-beat completion in that cycle never enters BUSY.
// BYPASS=0: the grant is registered, oreq appears one cycle after the request.
// -----------------------------------------------------------------------------
module cbus_rr_arbiter
  import cbus_rr_arbiter_pkg::*;
#(
  parameter int NUM_INPUTS  = 2,
  parameter int ROUND_ROBIN = 1,
  parameter int BYPASS      = 1,
  localparam int IDX_W      = arb_idx_w(NUM_INPUTS)
) (
  input  logic             clk,
  input  logic             reset,
  input  cbus_req_t        ireqs  [NUM_INPUTS],
  output cbus_resp_t       iresps [NUM_INPUTS],
  output cbus_req_t        oreq,
  input  cbus_resp_t       oresp,
  output logic             grant_valid,
  output logic [IDX_W-1:0] grant_index
);

  localparam logic [IDX_W-1:0] LAST_CH   = IDX_W'(NUM_INPUTS - 1);
  localparam logic             BYPASS_EN = (BYPASS != 0);

  arb_state_t       state_r, state_nxt_s;
  logic [IDX_W-1:0] own_r, own_nxt_s;
  logic [IDX_W-1:0] last_idx_r, last_nxt_s;
  logic [IDX_W-1:0] sel_s;
  logic             any_valid_s;
  logic [NUM_INPUTS-1:0] valid_vec_s;
  logic             done_s;
  logic             owner_valid_s;

  cbus_req_t        oreq_s;
  cbus_resp_t       iresps_s [NUM_INPUTS];
  logic             grant_valid_s;
  logic [IDX_W-1:0] grant_index_s;

  // Collect the per-channel valid bits for the selector.
  always_comb begin
    for (int i = 0; i < NUM_INPUTS; i++) begin
      valid_vec_s[i] = ireqs[i].valid;
    end
  end

  assign done_s        = oresp.ready & oresp.last;
  assign owner_valid_s = ireqs[own_r].valid;

  rr_select #(
    .NUM_INPUTS (NUM_INPUTS),
    .ROUND_ROBIN(ROUND_ROBIN)
  ) u_sel (
    .valid    (valid_vec_s),
    .last_idx (last_idx_r),
    .sel      (sel_s),
    .any_valid(any_valid_s)
  );

  // State, owner and rotation pointer; pointer resets so channel 0 leads.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r    <= ARB_IDLE;
      own_r      <= {IDX_W{1'b0}};
      last_idx_r <= LAST_CH;
    end else begin
      state_r    <= state_nxt_s;
      own_r      <= own_nxt_s;
      last_idx_r <= last_nxt_s;
    end
  end

  // Next-state and routing of request/response for the current owner.
  always_comb begin
    state_nxt_s   = state_r;
    own_nxt_s     = own_r;
    last_nxt_s    = last_idx_r;
    oreq_s        = '0;
    grant_valid_s = 1'b0;
    grant_index_s = {IDX_W{1'b0}};
    for (int i = 0; i < NUM_INPUTS; i++) begin
      iresps_s[i] = '0;
    end
    case (state_r)
      ARB_IDLE: begin
        if (any_valid_s) begin
          if (BYPASS_EN) begin
            oreq_s          = ireqs[sel_s];
            iresps_s[sel_s] = oresp;
            grant_valid_s   = 1'b1;
            grant_index_s   = sel_s;
            if (done_s) begin
              // Single beat finished in the grant cycle: no BUSY phase.
              last_nxt_s = sel_s;
            end else begin
              state_nxt_s = ARB_BUSY;
              own_nxt_s   = sel_s;
            end
          end else begin
            state_nxt_s = ARB_BUSY;
            own_nxt_s   = sel_s;
          end
        end else begin
          state_nxt_s = ARB_IDLE;
        end
      end
      ARB_BUSY: begin
        // Valid is forced so a glitching owner cannot truncate a burst.
        oreq_s          = ireqs[own_r];
        oreq_s.valid    = 1'b1;
        iresps_s[own_r] = oresp;
        grant_valid_s   = 1'b1;
        grant_index_s   = own_r;
        if (done_s) begin
          // Re-arbitration happens next cycle; no back-to-back issue here.
          state_nxt_s = ARB_IDLE;
          last_nxt_s  = own_r;
        end else begin
          state_nxt_s = ARB_BUSY;
        end
      end
      default: begin
        state_nxt_s = ARB_IDLE;
      end
    endcase
  end

  // Outputs are forced to zero for the whole time reset is held low.
  always_comb begin
    if (!reset) begin
      oreq        = '0;
      grant_valid = 1'b0;
      grant_index = {IDX_W{1'b0}};
      for (int i = 0; i < NUM_INPUTS; i++) begin
        iresps[i] = '0;
      end
    end else begin
      oreq        = oreq_s;
      grant_valid = grant_valid_s;
      grant_index = grant_index_s;
      for (int i = 0; i < NUM_INPUTS; i++) begin
        iresps[i] = iresps_s[i];
      end
    end
  end

  cbus_rr_arbiter_chk u_chk (
    .clk        (clk),
    .reset      (reset),
    .busy       (state_r == ARB_BUSY),
    .owner_valid(owner_valid_s)
  );

endmodule

// File: tb/tb_cbus_rr_arbiter.sv
// Bench for cbus_rr_arbiter: three 4-channel instances
//   u0: round-robin, bypass   u1: fixed priority, bypass   u2: round-robin, registered
// Directed steps from the test plan, then random traffic, all checked each
// cycle against a transaction-level reference model.
module tb_cbus_rr_arbiter;
  import cbus_rr_arbiter_pkg::*;

  logic clk;
  logic rst;

  cbus_req_t  req_m   [3][4];
  cbus_resp_t dresp_m [3];
  cbus_resp_t iresp_m [3][4];
  cbus_req_t  oreq_m  [3];
  logic       gv_m    [3];
  logic [1:0] gi_m    [3];

  // reference model: who holds the bus, who was served last
  bit  m_busy [3];
  int  m_own  [3];
  int  m_last [3];
  int  m_done [3];

  int         e_owner [3];
  logic       e_gv    [3];
  logic [1:0] e_gi    [3];
  cbus_req_t  e_oreq  [3];

  cbus_req_t  s_oreq  [3];
  cbus_resp_t s_iresp [3][4];
  logic       s_gv    [3];
  logic [1:0] s_gi    [3];

  int checks;
  int failures;
  int exp_rr [6] = '{0, 1, 2, 3, 0, 1};

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  for (genvar j = 0; j < 3; j++) begin : g
    cbus_req_t  rq [4];
    cbus_resp_t rs [4];
    cbus_req_t  oq;
    cbus_resp_t dr;
    logic       gv;
    logic [1:0] gi;
    for (genvar c = 0; c < 4; c++) begin : ch
      assign rq[c]         = req_m[j][c];
      assign iresp_m[j][c] = rs[c];
    end
    assign dr        = dresp_m[j];
    assign oreq_m[j] = oq;
    assign gv_m[j]   = gv;
    assign gi_m[j]   = gi;
    cbus_rr_arbiter #(
      .NUM_INPUTS (4),
      .ROUND_ROBIN((j == 1) ? 0 : 1),
      .BYPASS     ((j == 2) ? 0 : 1)
    ) u_dut (
      .clk        (clk),
      .reset      (rst),
      .ireqs      (rq),
      .iresps     (rs),
      .oreq       (oq),
      .oresp      (dr),
      .grant_valid(gv),
      .grant_index(gi)
    );
  end

  function automatic bit is_rr(input int j);
    return j != 1;
  endfunction

  function automatic bit is_byp(input int j);
    return j != 2;
  endfunction

  // winner among currently valid channels, -1 if none
  function automatic int pick(input int j);
    int c;
    if (is_rr(j)) begin
      for (int k = 1; k <= 4; k++) begin
        c = (m_last[j] + k) % 4;
        if (req_m[j][c].valid) return c;
      end
    end else begin
      for (int k = 0; k < 4; k++) begin
        if (req_m[j][k].valid) return k;
      end
    end
    return -1;
  endfunction

  task automatic chk(input string tag, input int j, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s dut=%0d observed=%0h expected=%0h", tag, j, got, exp);
    end
  endtask

  task automatic compute(input int j);
    int s;
    e_owner[j] = -1;
    e_gv[j]    = 1'b0;
    e_gi[j]    = 2'd0;
    e_oreq[j]  = '0;
    if (rst) begin
      if (m_busy[j]) begin
        e_owner[j]      = m_own[j];
        e_oreq[j]       = req_m[j][m_own[j]];
        e_oreq[j].valid = 1'b1;
      end else begin
        s = pick(j);
        if (s >= 0 && is_byp(j)) begin
          e_owner[j] = s;
          e_oreq[j]  = req_m[j][s];
        end
      end
      if (e_owner[j] >= 0) begin
        e_gv[j] = 1'b1;
        e_gi[j] = 2'(e_owner[j]);
      end
    end
  endtask

  task automatic update(input int j);
    int  s;
    bit  fin;
    fin       = dresp_m[j].ready && dresp_m[j].last;
    m_done[j] = -1;
    if (!rst) begin
      m_busy[j] = 1'b0;
      m_last[j] = 3;
    end else if (m_busy[j]) begin
      if (fin) begin
        m_busy[j] = 1'b0;
        m_last[j] = m_own[j];
        m_done[j] = m_own[j];
      end
    end else begin
      s = pick(j);
      if (s >= 0) begin
        if (is_byp(j) && fin) begin
          m_last[j] = s;
          m_done[j] = s;
        end else begin
          m_busy[j] = 1'b1;
          m_own[j]  = s;
        end
      end
    end
  endtask

  // one clock: check at negedge, advance model at posedge
  task automatic tick();
    cbus_resp_t er;
    for (int j = 0; j < 3; j++) compute(j);
    @(negedge clk);
    for (int j = 0; j < 3; j++) begin
      s_oreq[j] = oreq_m[j];
      s_gv[j]   = gv_m[j];
      s_gi[j]   = gi_m[j];
      chk("grant_valid", j, 128'(gv_m[j]), 128'(e_gv[j]));
      chk("grant_index", j, 128'(gi_m[j]), 128'(e_gi[j]));
      chk("oreq", j, 128'(oreq_m[j]), 128'(e_oreq[j]));
      for (int c = 0; c < 4; c++) begin
        s_iresp[j][c] = iresp_m[j][c];
        if (c == e_owner[j]) er = dresp_m[j];
        else er = '0;
        chk("iresps", j * 10 + c, 128'(iresp_m[j][c]), 128'(er));
      end
    end
    @(posedge clk);
    for (int j = 0; j < 3; j++) update(j);
    #1;
  endtask

  task automatic set_req(input int j, input int c, input logic [31:0] addr, input logic [3:0] len);
    req_m[j][c]       = '0;
    req_m[j][c].valid = 1'b1;
    req_m[j][c].addr  = addr;
    req_m[j][c].wdata = ~addr;
    req_m[j][c].len   = len;
  endtask

  task automatic set_resp(input int j, input logic ready, input logic last, input logic [31:0] rdata);
    dresp_m[j].ready = ready;
    dresp_m[j].last  = last;
    dresp_m[j].rdata = rdata;
  endtask

  task automatic clear_all();
    for (int j = 0; j < 3; j++) begin
      dresp_m[j] = '0;
      for (int c = 0; c < 4; c++) req_m[j][c] = '0;
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rst      = 1'b0;
    clear_all();
    for (int j = 0; j < 3; j++) begin
      m_busy[j] = 1'b0;
      m_own[j]  = 0;
      m_last[j] = 3;
      m_done[j] = -1;
    end

    // reset: outputs held at zero even with a pending bypass request
    set_req(0, 0, 32'h0000_0100, 4'd0);
    set_resp(0, 1'b1, 1'b1, 32'h0000_0001);
    tick();
    chk("reset_grant_valid", 0, 128'(s_gv[0]), 128'(1'b0));
    chk("reset_oreq", 0, 128'(s_oreq[0]), 128'(0));
    rst = 1'b1;
    clear_all();

    // single beat on channel 1, completed in the grant cycle
    set_req(0, 1, 32'h8000_0000, 4'd0);
    set_resp(0, 1'b1, 1'b1, 32'h0000_1234);
    tick();
    chk("bypass_oreq_valid", 0, 128'(s_oreq[0].valid), 128'(1'b1));
    chk("bypass_oreq_addr", 0, 128'(s_oreq[0].addr), 128'(32'h8000_0000));
    chk("bypass_iresp1_ready", 0, 128'(s_iresp[0][1].ready), 128'(1'b1));
    chk("bypass_grant_index", 0, 128'(s_gi[0]), 128'(2'd1));
    clear_all();
    tick();
    chk("bypass_grant_one_cycle", 0, 128'(s_gv[0]), 128'(1'b0));
    // pointer now at 1: with everyone asking, channel 2 is next
    for (int c = 0; c < 4; c++) set_req(0, c, 32'h10 * c, 4'd0);
    set_resp(0, 1'b1, 1'b1, 32'h0);
    tick();
    chk("bypass_last_idx_1", 0, 128'(s_gi[0]), 128'(2'd2));
    clear_all();

    // registered grant: oreq one cycle after the request
    set_req(2, 0, 32'h0000_1000, 4'd0);
    tick();
    chk("reg_first_cycle_valid", 2, 128'(s_oreq[2].valid), 128'(1'b0));
    chk("reg_first_cycle_grant", 2, 128'(s_gv[2]), 128'(1'b0));
    set_resp(2, 1'b1, 1'b1, 32'h0000_cafe);
    tick();
    chk("reg_second_cycle_valid", 2, 128'(s_oreq[2].valid), 128'(1'b1));
    chk("reg_iresp0_rdata", 2, 128'(s_iresp[2][0].rdata), 128'(32'h0000_cafe));
    chk("reg_iresp1_zero", 2, 128'(s_iresp[2][1]), 128'(0));
    clear_all();
    tick();

    // fairness: all four valid, one beat per transaction
    rst = 1'b0;
    tick();
    rst = 1'b1;
    for (int j = 0; j < 2; j++) begin
      for (int c = 0; c < 4; c++) set_req(j, c, 32'h100 * c, 4'd0);
      set_resp(j, 1'b1, 1'b1, 32'h0);
    end
    for (int t = 0; t < 6; t++) begin
      tick();
      chk("rr_sequence", 0, 128'(s_gi[0]), 128'(exp_rr[t]));
      chk("fixed_priority_ch0", 1, 128'(s_gi[1]), 128'(2'd0));
    end
    clear_all();

    // 4-beat burst on channel 0; channel 1 arrives during beat 2
    set_req(0, 0, 32'h0000_2000, 4'd3);
    for (int b = 1; b <= 4; b++) begin
      if (b == 2) set_req(0, 1, 32'h0000_3000, 4'd0);
      set_resp(0, 1'b1, (b == 4), 32'h0 + b);
      tick();
      chk("burst_oreq_addr", 0, 128'(s_oreq[0].addr), 128'(32'h0000_2000));
      chk("burst_grant_index", 0, 128'(s_gi[0]), 128'(2'd0));
      chk("burst_iresp1_zero", 0, 128'(s_iresp[0][1]), 128'(0));
    end
    req_m[0][0] = '0;
    set_resp(0, 1'b1, 1'b1, 32'h0);
    tick();
    chk("burst_next_grant_valid", 0, 128'(s_gv[0]), 128'(1'b1));
    chk("burst_next_grant_index", 0, 128'(s_gi[0]), 128'(2'd1));
    chk("burst_next_oreq_addr", 0, 128'(s_oreq[0].addr), 128'(32'h0000_3000));
    clear_all();

    // reset during beat 2: pointer returns to channel 0 first
    set_req(0, 2, 32'h0000_5000, 4'd0);
    set_resp(0, 1'b1, 1'b1, 32'h0);
    tick();
    clear_all();
    set_req(0, 3, 32'h0000_4000, 4'd3);
    set_resp(0, 1'b1, 1'b0, 32'h0);
    tick();
    rst = 1'b0;
    tick();
    chk("midreset_oreq_valid", 0, 128'(s_oreq[0].valid), 128'(1'b0));
    chk("midreset_grant_valid", 0, 128'(s_gv[0]), 128'(1'b0));
    rst = 1'b1;
    clear_all();
    for (int c = 0; c < 4; c++) set_req(0, c, 32'h20 * c, 4'd0);
    set_resp(0, 1'b1, 1'b1, 32'h0);
    tick();
    chk("midreset_ch0_first", 0, 128'(s_gi[0]), 128'(2'd0));
    clear_all();

    // random traffic against the model
    for (int t = 0; t < 1500; t++) begin
      for (int j = 0; j < 3; j++) begin
        if (m_done[j] >= 0) req_m[j][m_done[j]] = '0;
        for (int c = 0; c < 4; c++) begin
          if (!req_m[j][c].valid && $urandom_range(3) == 0) begin
            req_m[j][c].valid = 1'b1;
            req_m[j][c].write = 1'($urandom_range(1));
            req_m[j][c].addr  = $urandom;
            req_m[j][c].wdata = $urandom;
            req_m[j][c].len   = 4'($urandom_range(15));
          end
        end
      end
      rst = ($urandom_range(299) != 0);
      for (int j = 0; j < 3; j++) begin
        compute(j);
        dresp_m[j] = '0;
        if (e_owner[j] >= 0) begin
          dresp_m[j].ready = 1'($urandom_range(1));
          dresp_m[j].last  = dresp_m[j].ready && ($urandom_range(2) == 0);
          dresp_m[j].rdata = $urandom;
        end
      end
      tick();
    end

    rst = 1'b1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
